// File: rtl/grpbuf_write_arbiter.sv
// grpbuf_write_arbiter: round-robin arbiter muxing up to five producers onto the group buffer write/read-back port
module grpbuf_write_arbiter #(
  parameter int N_REQ       = 5,
  parameter int DW          = 12,
  parameter int AW          = 10,
  parameter int TIMEOUT_CYC = 4096,
  parameter int GUARD_CYC   = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [N_REQ-1:0]    req,
  input  logic [N_REQ*DW-1:0] req_data,
  input  logic [N_REQ*AW-1:0] req_addr,
  input  logic [N_REQ-1:0]    req_wren,
  input  logic [N_REQ*AW-1:0] req_rdaddr,
  input  logic [N_REQ-1:0]    req_rden,
  input  logic                swch,
  output logic [N_REQ-1:0]    gnt,
  output logic [DW-1:0]       comm_data,
  output logic [AW-1:0]       comm_addr,
  output logic                comm_wren,
  output logic [AW-1:0]       comm_rdaddr,
  output logic                comm_rden,
  output logic                active,
  output logic                timeout_flag,
  output logic [2:0]          timeout_id
);
  localparam int WW = $clog2(TIMEOUT_CYC);
  localparam int GW = $clog2(GUARD_CYC) + 1;
  typedef enum logic [1:0] {IDLE, HOLD, GUARD} state_t;
  state_t           state_q, state_d;
  logic [N_REQ-1:0] gnt_q, gnt_d, mask_q, mask_d, elig;
  logic [2:0]       id_q, id_d, ptr_q, ptr_d, tid_q, tid_d, pick, cand;
  logic [2:0]       sync_q, sync_d;
  logic             pick_ok, pend_q, pend_d, tflag_q, tflag_d, sw_edge, hold_d;
  logic [WW-1:0]    wd_q, wd_d;
  logic [GW-1:0]    gc_q, gc_d;
  logic [DW-1:0]    data_q, data_d;
  logic [AW-1:0]    addr_q, addr_d, rdaddr_q, rdaddr_d;
  logic             wren_q, wren_d, rden_q, rden_d;

  assign elig    = req & ~mask_q;
  assign sync_d  = {sync_q[1:0], swch};
  assign sw_edge = sync_q[1] ^ sync_q[2];

  // pick the first eligible requester after the pointer, wrapping to 0
  always_comb begin
    pick_ok = 1'b0;
    pick    = '0;
    cand    = '0;
    for (int k = N_REQ; k >= 1; k--) begin
      cand = 3'((int'(ptr_q) + k) % N_REQ);
      if (elig[cand]) begin
        pick_ok = 1'b1;
        pick    = cand;
      end
    end
  end

  // arbitration state machine; the IDLE cycle after a guard is the last of its dead cycles
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    id_d    = id_q;
    ptr_d   = ptr_q;
    pend_d  = pend_q | sw_edge;
    wd_d    = wd_q;
    gc_d    = gc_q;
    mask_d  = mask_q;
    tflag_d = tflag_q;
    tid_d   = tid_q;
    case (state_q)
      IDLE: begin
        if (pend_d) begin
          state_d = GUARD;
          gc_d    = GW'(1);
          pend_d  = 1'b0;
        end else if (pick_ok) begin
          state_d = HOLD;
          gnt_d   = N_REQ'(1) << pick;
          id_d    = pick;
          wd_d    = '0;
        end
      end
      HOLD: begin
        if (!req[id_q] || wd_q == WW'(TIMEOUT_CYC - 1)) begin
          if (req[id_q]) begin
            tflag_d        = 1'b1;
            tid_d          = id_q;
            mask_d[id_q]   = 1'b1;
          end
          state_d = pend_d ? GUARD : IDLE;
          gnt_d   = '0;
          ptr_d   = id_q;
          gc_d    = GW'(1);
          pend_d  = 1'b0;
        end else begin
          wd_d = wd_q + WW'(1);
        end
      end
      GUARD: begin
        pend_d = 1'b0;
        if (sw_edge) begin
          gc_d = GW'(1);
        end else if (gc_q >= GW'(GUARD_CYC - 1)) begin
          state_d = IDLE;
        end else begin
          gc_d = gc_q + GW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    mask_d = mask_d & req;
  end

  // port mux, registered alongside the grant so data lines up with gnt
  always_comb begin
    hold_d   = |gnt_d;
    data_d   = hold_d ? req_data[int'(id_d)*DW +: DW] : '0;
    addr_d   = hold_d ? req_addr[int'(id_d)*AW +: AW] : '0;
    rdaddr_d = hold_d ? req_rdaddr[int'(id_d)*AW +: AW] : '0;
    wren_d   = hold_d & req_wren[id_d];
    rden_d   = hold_d & req_rden[id_d];
  end

  // state and output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      gnt_q    <= '0;
      id_q     <= '0;
      ptr_q    <= 3'(N_REQ - 1);
      pend_q   <= 1'b0;
      wd_q     <= '0;
      gc_q     <= '0;
      mask_q   <= '0;
      tflag_q  <= 1'b0;
      tid_q    <= '0;
      sync_q   <= '0;
      data_q   <= '0;
      addr_q   <= '0;
      rdaddr_q <= '0;
      wren_q   <= 1'b0;
      rden_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      id_q     <= id_d;
      ptr_q    <= ptr_d;
      pend_q   <= pend_d;
      wd_q     <= wd_d;
      gc_q     <= gc_d;
      mask_q   <= mask_d;
      tflag_q  <= tflag_d;
      tid_q    <= tid_d;
      sync_q   <= sync_d;
      data_q   <= data_d;
      addr_q   <= addr_d;
      rdaddr_q <= rdaddr_d;
      wren_q   <= wren_d;
      rden_q   <= rden_d;
    end
  end

  assign gnt          = gnt_q;
  assign comm_data    = data_q;
  assign comm_addr    = addr_q;
  assign comm_wren    = wren_q;
  assign comm_rdaddr  = rdaddr_q;
  assign comm_rden    = rden_q;
  assign active       = |gnt_q;
  assign timeout_flag = tflag_q;
  assign timeout_id   = tid_q;
endmodule

// File: tb/tb_grpbuf_write_arbiter.sv
// tb_grpbuf_write_arbiter: directed and random checks of grpbuf_write_arbiter against a behavioural model
module tb_grpbuf_write_arbiter;
  localparam int N  = 5;
  localparam int DW = 12;
  localparam int AW = 10;
  localparam int TO = 4096;
  localparam int G  = 16;
  logic clk = 1'b0, reset = 1'b0, swch = 1'b0;
  logic [N-1:0] req = '0, req_wren = '0, req_rden = '0;
  logic [N*DW-1:0] req_data = '0;
  logic [N*AW-1:0] req_addr = '0, req_rdaddr = '0;
  logic [N-1:0] gnt;
  logic [DW-1:0] comm_data;
  logic [AW-1:0] comm_addr, comm_rdaddr;
  logic comm_wren, comm_rden, active, timeout_flag;
  logic [2:0] timeout_id;
  int errors = 0, checks = 0;

  always #5 clk = ~clk;

  grpbuf_write_arbiter dut (
    .clk(clk), .reset(reset), .req(req), .req_data(req_data), .req_addr(req_addr),
    .req_wren(req_wren), .req_rdaddr(req_rdaddr), .req_rden(req_rden), .swch(swch),
    .gnt(gnt), .comm_data(comm_data), .comm_addr(comm_addr), .comm_wren(comm_wren),
    .comm_rdaddr(comm_rdaddr), .comm_rden(comm_rden), .active(active),
    .timeout_flag(timeout_flag), .timeout_id(timeout_id)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // behavioural model: who owns the port, how long, guard countdown, pending switch
  int m_owner = -1, m_held = 0, m_guard = 0, m_ptr = N - 1, m_tid = 0;
  bit m_pend = 0, m_tf = 0, ev = 0, found = 0;
  bit [2:0] m_sw = '0;
  bit [N-1:0] m_mask = '0;
  logic [N-1:0] e_gnt = '0;
  logic [DW-1:0] e_data = '0;
  logic [AW-1:0] e_addr = '0, e_rdaddr = '0;
  logic e_wren = 0, e_rden = 0;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_owner = -1; m_held = 0; m_guard = 0; m_pend = 0; m_ptr = N - 1;
      m_mask = '0; m_sw = '0; m_tf = 0; m_tid = 0;
    end else begin
      ev = m_sw[1] ^ m_sw[2];
      m_sw = {m_sw[1:0], swch};
      if (m_owner >= 0) begin
        m_pend = m_pend | ev;
        if (((req >> m_owner) & 1) == 0 || m_held == TO - 1) begin
          if (((req >> m_owner) & 1) != 0) begin
            m_tf = 1; m_tid = m_owner; m_mask = m_mask | (N'(1) << m_owner);
          end
          m_ptr = m_owner;
          m_owner = -1;
          if (m_pend) begin m_guard = G - 1; m_pend = 0; end
        end else m_held++;
      end else if (m_guard > 0) begin
        if (ev) m_guard = G - 1; else m_guard--;
      end else if (ev || m_pend) begin
        m_guard = G - 1; m_pend = 0;
      end else begin
        found = 0;
        for (int k = 1; k <= N; k++) begin
          int c;
          c = (m_ptr + k) % N;
          if (!found && (((req & ~m_mask) >> c) & 1) != 0) begin
            found = 1; m_owner = c; m_held = 0;
          end
        end
      end
      m_mask = m_mask & req;
    end
    e_gnt    = m_owner >= 0 ? N'(1) << m_owner : '0;
    e_data   = m_owner >= 0 ? DW'(req_data >> (m_owner * DW)) : '0;
    e_addr   = m_owner >= 0 ? AW'(req_addr >> (m_owner * AW)) : '0;
    e_rdaddr = m_owner >= 0 ? AW'(req_rdaddr >> (m_owner * AW)) : '0;
    e_wren   = m_owner >= 0 && ((req_wren >> m_owner) & 1) != 0;
    e_rden   = m_owner >= 0 && ((req_rden >> m_owner) & 1) != 0;
  end

  always @(negedge clk) begin
    chk("mon_gnt", 32'(gnt), 32'(e_gnt));
    chk("mon_data", 32'(comm_data), 32'(e_data));
    chk("mon_addr", 32'(comm_addr), 32'(e_addr));
    chk("mon_rdaddr", 32'(comm_rdaddr), 32'(e_rdaddr));
    chk("mon_wren", 32'(comm_wren), 32'(e_wren));
    chk("mon_rden", 32'(comm_rden), 32'(e_rden));
    chk("mon_active", 32'(active), 32'(e_gnt != 0));
    chk("mon_tflag", 32'(timeout_flag), 32'(m_tf));
    chk("mon_tid", 32'(timeout_id), 32'(m_tid));
    chk("mon_onehot", 32'($countones(gnt) <= 1), 1);
  end

  task automatic wait_gnt(output int idx);
    int n = 0;
    while (gnt == 0 && n < 40) begin @(negedge clk); n++; end
    idx = -1;
    for (int i = 0; i < N; i++) if (gnt[i]) idx = i;
  endtask

  initial begin
    int idx, n;
    repeat (3) @(negedge clk);
    chk("rst_gnt", 32'(gnt), 0);
    chk("rst_flag", 32'(timeout_flag), 0);
    reset = 1'b1;
    req = 5'b00101;
    @(negedge clk); chk("t1_first", 32'(gnt), 1);
    req = 5'b00100;
    @(negedge clk); chk("t1_dead", 32'(gnt), 0);
    @(negedge clk); chk("t1_second", 32'(gnt), 4);
    req = '0; repeat (3) @(negedge clk);
    req = 5'b10000; wait_gnt(idx); chk("pre4", 32'(idx), 4);
    req = '0; repeat (3) @(negedge clk);
    req = '1;
    for (int k = 0; k < 6; k++) begin
      wait_gnt(idx); chk("rr_order", 32'(idx), 32'(k % N));
      if (idx >= 0) begin
        repeat (7) @(negedge clk);
        chk("rr_hold", 32'(gnt), 32'(1 << idx));
        req[idx] = 1'b0;
        @(negedge clk); chk("rr_dead", 32'(gnt), 0);
        req[idx] = 1'b1;
      end
    end
    req = '0; repeat (3) @(negedge clk);
    req_data[2*DW +: DW] = 12'hABC; req_addr[2*AW +: AW] = 10'h155;
    req_data[3*DW +: DW] = 12'h123; req_addr[3*AW +: AW] = 10'h2AA;
    req_wren = 5'b01100; req = 5'b01100;
    @(negedge clk);
    chk("t3_gnt", 32'(gnt), 4);
    chk("t3_wren", 32'(comm_wren), 1);
    chk("t3_addr", 32'(comm_addr), 'h155);
    chk("t3_data", 32'(comm_data), 'hABC);
    req_wren = 5'b01000;
    @(negedge clk);
    chk("t3_wren_off", 32'(comm_wren), 0);
    chk("t3_addr_kept", 32'(comm_addr), 'h155);
    req = '0; req_wren = '0; repeat (3) @(negedge clk);
    req = 5'b00010; wait_gnt(idx); chk("sw_gnt1", 32'(idx), 1);
    swch = 1'b1; req[3] = 1'b1;
    repeat (5) @(negedge clk); chk("sw_keep_a", 32'(gnt), 2);
    swch = 1'b0;
    repeat (5) @(negedge clk); chk("sw_keep_b", 32'(gnt), 2);
    req[1] = 1'b0;
    n = 0;
    @(negedge clk);
    while (gnt == 0 && n < 40) begin n++; @(negedge clk); end
    chk("sw_guard_len", 32'(n), G);
    chk("sw_after", 32'(gnt), 8);
    req = '0; repeat (3) @(negedge clk);
    req = 5'b10000; wait_gnt(idx); chk("to_gnt4", 32'(idx), 4);
    n = 0;
    while (gnt == 5'b10000 && n < TO + 50) begin n++; @(negedge clk); end
    chk("to_len", 32'(n), TO);
    chk("to_flag", 32'(timeout_flag), 1);
    chk("to_id", 32'(timeout_id), 4);
    repeat (10) begin @(negedge clk); chk("to_masked", 32'(gnt), 0); end
    req = '0; @(negedge clk);
    req = 5'b10000; wait_gnt(idx); chk("to_regrant", 32'(idx), 4);
    req = '0; repeat (3) @(negedge clk);
    req_addr[1*AW +: AW] = 10'h3F0; req_data[1*DW +: DW] = 12'h5A5;
    req_wren = 5'b00010; req = 5'b00110;
    wait_gnt(idx); chk("rs_gnt1", 32'(idx), 1);
    chk("rs_wren_pre", 32'(comm_wren), 1);
    #2 reset = 1'b0;
    #1;
    chk("rs_gnt", 32'(gnt), 0);
    chk("rs_wren", 32'(comm_wren), 0);
    chk("rs_addr", 32'(comm_addr), 0);
    chk("rs_data", 32'(comm_data), 0);
    chk("rs_active", 32'(active), 0);
    chk("rs_tflag", 32'(timeout_flag), 0);
    chk("rs_tid", 32'(timeout_id), 0);
    @(negedge clk);
    reset = 1'b1; req = 5'b11010;
    @(negedge clk); chk("rs_first", 32'(gnt), 2);
    req = '0; req_wren = '0; repeat (3) @(negedge clk);
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      for (int i = 0; i < N; i++) if ($urandom_range(7) == 0) req[i] = ~req[i];
      req_data   = (N*DW)'({$urandom(), $urandom()});
      req_addr   = (N*AW)'({$urandom(), $urandom()});
      req_rdaddr = (N*AW)'({$urandom(), $urandom()});
      req_wren   = N'($urandom());
      req_rden   = N'($urandom());
      if ($urandom_range(150) == 0) swch = ~swch;
    end
    req = '0; repeat (5) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
